// File: rtl/apb_pkg.sv
// Shared definitions for the Wishbone-to-APB bridge.
//   - apb_state_e         : bridge FSM states (IDLE, SETUP, ACCESS, DONE)
//   - APB_STRB_W          : width of the APB4 write strobe / Wishbone byte select
//   - APB_TIMEOUT_DEFAULT : default ACCESS-phase watchdog limit in cycles
package apb_pkg;

  localparam int APB_STRB_W          = 4;
  localparam int APB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Clear/enable cycle counter with a terminal flag, used as the ACCESS-phase
// watchdog of the bridge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear (has priority over en)
//   en         : count one cycle
//   terminal   : high while the count equals LAST
module apb_timeout_ctr #(
  parameter int WIDTH = 8,
  parameter int LAST  = 254
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  logic [WIDTH-1:0] count;

  // The count holds the number of ACCESS cycles already completed, so the
  // terminal flag is raised during the last allowed cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == WIDTH'(LAST));

endmodule

// File: rtl/wb_to_apb_bridge.sv
// Wishbone-classic slave to APB master bridge. Each Wishbone cycle becomes
// a single APB transfer (SETUP then ACCESS) and is terminated by a one-cycle
// ack (success) or err (pslverr or watchdog expiry) in the DONE state.
// Ports:
//   clk, rst_n                   : shared clock, asynchronous active-low reset
//   wb_cyc_i/stb_i/we_i/sel_i    : Wishbone request controls
//   wb_adr_i, wb_dat_i           : Wishbone address and write data
//   wb_ack_o, wb_err_o, wb_dat_o : Wishbone termination and read data
//   paddr/psel/penable/pwrite    : APB master request
//   pwdata, pstrb                : APB write data and APB4 strobes
//   pready, prdata, pslverr      : APB completer response
module wb_to_apb_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [APB_STRB_W-1:0] wb_sel_i,
  input  logic [ADDR_W-1:0]     wb_adr_i,
  input  logic [DATA_W-1:0]     wb_dat_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [DATA_W-1:0]     wb_dat_o,
  output logic [ADDR_W-1:0]     paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_W-1:0]     pwdata,
  output logic [APB_STRB_W-1:0] pstrb,
  input  logic                  pready,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pslverr
);

  // Counter just wide enough to reach TIMEOUT_CYCLES-1; a zero timeout
  // keeps a 1-bit counter whose flag is ignored.
  localparam int CTR_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int CTR_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  apb_state_e            state, state_d;
  logic [ADDR_W-1:0]     paddr_d;
  logic [DATA_W-1:0]     pwdata_d;
  logic [DATA_W-1:0]     wb_dat_d;
  logic [APB_STRB_W-1:0] pstrb_d;
  logic                  pwrite_d;
  logic                  psel_d;
  logic                  penable_d;
  logic                  wb_ack_d;
  logic                  wb_err_d;
  logic                  ctr_terminal;
  logic                  timeout_hit;

  apb_timeout_ctr #(
    .WIDTH (CTR_W),
    .LAST  (CTR_LAST)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state != ST_ACCESS),
    .en       (state == ST_ACCESS),
    .terminal (ctr_terminal)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ctr_terminal;

  // Every output is registered: this block holds the state and all output
  // registers, and reset clears them at once so an in-flight APB transfer is
  // abandoned with psel dropping immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      paddr    <= '0;
      pwdata   <= '0;
      pstrb    <= '0;
      pwrite   <= 1'b0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state    <= state_d;
      paddr    <= paddr_d;
      pwdata   <= pwdata_d;
      pstrb    <= pstrb_d;
      pwrite   <= pwrite_d;
      psel     <= psel_d;
      penable  <= penable_d;
      wb_ack_o <= wb_ack_d;
      wb_err_o <= wb_err_d;
      wb_dat_o <= wb_dat_d;
    end
  end

  // Next-state and next-output logic. Request fields are captured only in
  // IDLE so they stay stable through SETUP/ACCESS and hold afterwards.
  // Terminations are gated by wb_cyc_i so an abandoned Wishbone cycle still
  // finishes on APB but never sees a stray ack/err.
  always_comb begin
    state_d  = state;
    paddr_d  = paddr;
    pwdata_d = pwdata;
    pstrb_d  = pstrb;
    pwrite_d = pwrite;
    wb_dat_d = wb_dat_o;
    wb_ack_d = 1'b0;
    wb_err_d = 1'b0;

    case (state)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          state_d  = ST_SETUP;
          paddr_d  = wb_adr_i;
          pwdata_d = wb_dat_i;
          pwrite_d = wb_we_i;
          pstrb_d  = wb_we_i ? wb_sel_i : '0;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d  = ST_DONE;
          wb_ack_d = wb_cyc_i & ~pslverr;
          wb_err_d = wb_cyc_i & pslverr;
          if (!pwrite && !pslverr && wb_cyc_i) begin
            wb_dat_d = prdata;
          end
        end else if (timeout_hit) begin
          state_d  = ST_DONE;
          wb_err_d = wb_cyc_i;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d = (state_d == ST_ACCESS);
  end

endmodule

// File: tb/tb_wb_to_apb_bridge.sv
// Self-checking bench for wb_to_apb_bridge. A Wishbone driver issues
// directed and random transfers, an APB completer model answers them with
// planned wait states / errors, and two monitors compare the APB request and
// the Wishbone termination against expectations queued at issue time.
module tb_wb_to_apb_bridge;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] wb_dat_o;
  logic [31:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } apb_exp_t;

  typedef struct {
    int          waits;
    logic        slverr;
    logic [31:0] rdata;
  } slave_plan_t;

  typedef struct {
    logic        is_err;
    logic [31:0] rdata;
    int          issue;
    int          lat;
  } resp_exp_t;

  apb_exp_t    apb_q[$];
  slave_plan_t plan_q[$];
  resp_exp_t   resp_q[$];
  logic [31:0] model_rdata = 32'h0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cycle_cnt = 0;

  wb_to_apb_bridge #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_sel_i (wb_sel_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .wb_dat_o (wb_dat_o),
    .paddr    (paddr),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .pstrb    (pstrb),
    .pready   (pready),
    .prdata   (prdata),
    .pslverr  (pslverr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // APB completer: picks up the plan at SETUP, then holds pready low for the
  // planned number of ACCESS cycles; prdata is noise except on the ready cycle.
  initial begin : apb_slave
    slave_plan_t cur;
    int          left;
    bit          active;
    active  = 0;
    left    = 0;
    cur.waits = 0; cur.slverr = 0; cur.rdata = 0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      prdata  = $urandom;
      pslverr = 1'b0;
      pready  = 1'b0;
      if (!rst_n) begin
        active = 0;
      end else if (psel && !penable) begin
        if (plan_q.size() > 0) cur = plan_q.pop_front();
        else cur.waits = 1000;
        left   = cur.waits;
        active = 1;
      end else if (psel && penable && active) begin
        if (left == 0) begin
          pready  = 1'b1;
          pslverr = cur.slverr;
          prdata  = cur.rdata;
        end else begin
          left--;
        end
      end else begin
        active = 0;
      end
    end
  end

  // APB request monitor: fields must match the issued request at SETUP and
  // stay unchanged across every ACCESS cycle.
  initial begin : apb_monitor
    apb_exp_t cur;
    cur.addr = 0; cur.we = 0; cur.wdata = 0; cur.strb = 0;
    forever begin
      @(negedge clk);
      if (rst_n && psel && !penable) begin
        checkOutput("apb_setup_expected", 32'(apb_q.size() > 0), 32'd1);
        if (apb_q.size() > 0) begin
          cur = apb_q.pop_front();
          checkOutput("paddr", paddr, cur.addr);
          checkOutput("pwrite", 32'(pwrite), 32'(cur.we));
          checkOutput("pwdata", pwdata, cur.wdata);
          checkOutput("pstrb", 32'(pstrb), 32'(cur.strb));
        end
      end else if (rst_n && psel && penable) begin
        checkOutput("access_stable", {paddr ^ cur.addr} | {pwdata ^ cur.wdata}
                    | 32'({pwrite, pstrb} ^ {cur.we, cur.strb}), 32'h0);
      end
    end
  end

  // Wishbone response monitor: each ack/err pulse pops one expectation.
  initial begin : resp_monitor
    resp_exp_t r;
    forever begin
      @(negedge clk);
      if (rst_n && (wb_ack_o || wb_err_o)) begin
        checkOutput("ack_err_exclusive", 32'(wb_ack_o & wb_err_o), 32'd0);
        checkOutput("resp_expected", 32'(resp_q.size() > 0), 32'd1);
        if (resp_q.size() > 0) begin
          r = resp_q.pop_front();
          checkOutput("resp_kind_err", 32'(wb_err_o), 32'(r.is_err));
          checkOutput("wb_dat_o", wb_dat_o, r.rdata);
          checkOutput("resp_latency", 32'(cycle_cnt - r.issue), 32'(r.lat));
        end
      end
    end
  end

  // Issue one Wishbone transfer (caller sits just after a rising edge) and
  // queue what the APB side and the Wishbone termination should look like.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input int waits, input logic slverr,
                               input logic [31:0] rdata);
    apb_exp_t    a;
    slave_plan_t p;
    resp_exp_t   r;
    bit          seen;
    a.addr = adr; a.we = we; a.wdata = dat; a.strb = we ? sel : 4'h0;
    apb_q.push_back(a);
    p.waits = waits; p.slverr = slverr; p.rdata = rdata;
    plan_q.push_back(p);
    r.issue = cycle_cnt;
    if (waits >= TIMEOUT) begin
      r.is_err = 1'b1;
      r.lat    = 2 + TIMEOUT;
    end else begin
      r.is_err = slverr;
      r.lat    = 3 + waits;
      if (!we && !slverr) model_rdata = rdata;
    end
    r.rdata = model_rdata;
    resp_q.push_back(r);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = wb_ack_o | wb_err_o;
    end
    checkOutput("resp_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    wb_adr_i = $urandom; wb_dat_i = $urandom; wb_we_i = $urandom_range(0, 1);
  endtask

  // Write whose Wishbone cycle is abandoned during ACCESS: APB must finish
  // and no termination may reach the master.
  task automatic dropCycTransfer(input logic [31:0] adr, input logic [31:0] dat, input int waits);
    apb_exp_t    a;
    slave_plan_t p;
    int          pulses;
    bit          in_access;
    a.addr = adr; a.we = 1'b1; a.wdata = dat; a.strb = 4'hF;
    apb_q.push_back(a);
    p.waits = waits; p.slverr = 1'b0; p.rdata = 32'h0;
    plan_q.push_back(p);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = 4'hF;
    in_access = 0;
    for (int i = 0; i < 10 && !in_access; i++) begin
      @(negedge clk);
      in_access = penable;
    end
    checkOutput("drop_reached_access", 32'(in_access), 32'd1);
    @(posedge clk);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < waits + 4; i++) begin
      @(negedge clk);
      if (wb_ack_o || wb_err_o) pulses++;
    end
    checkOutput("no_pulse_on_cyc_drop", 32'(pulses), 32'd0);
    checkOutput("psel_idle_after_drop", 32'(psel), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Reset while a transfer sits in ACCESS; outputs must clear without a clock.
  task automatic resetMidAccess();
    apb_exp_t    a;
    slave_plan_t p;
    bit          in_access;
    a.addr = 32'h26000030; a.we = 1'b0; a.wdata = 32'h0; a.strb = 4'h0;
    apb_q.push_back(a);
    p.waits = 20; p.slverr = 1'b0; p.rdata = 32'h0;
    plan_q.push_back(p);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 32'h26000030; wb_dat_i = 32'h0; wb_sel_i = 4'hF;
    in_access = 0;
    for (int i = 0; i < 10 && !in_access; i++) begin
      @(negedge clk);
      in_access = penable;
    end
    checkOutput("rst_reached_access", 32'(in_access), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_psel", 32'(psel), 32'd0);
    checkOutput("rst_async_penable", 32'(penable), 32'd0);
    checkOutput("rst_async_ack_err", 32'({wb_ack_o, wb_err_o}), 32'd0);
    checkOutput("rst_async_dat", wb_dat_o, 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    apb_q.delete();
    plan_q.delete();
    model_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    logic        we, slverr;
    int          waits;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = 0;
    wb_adr_i = 0; wb_dat_i = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_psel", 32'(psel), 32'd0);
    checkOutput("reset_penable", 32'(penable), 32'd0);
    checkOutput("reset_ack_err", 32'({wb_ack_o, wb_err_o}), 32'd0);
    checkOutput("reset_dat", wb_dat_o, 32'h0);
    checkOutput("reset_paddr", paddr, 32'h0);
    checkOutput("reset_pstrb", 32'(pstrb), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 32'h26000010, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h26000004, 32'h0BADF00D, 4'hF, 2, 1'b0, 32'h12345678);
    applyStimulus(1'b0, 32'h26000008, 32'h0, 4'h3, 1, 1'b1, 32'hCAFEF00D);
    applyStimulus(1'b1, 32'h2600000C, 32'h55AA55AA, 4'h5, 100, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h26000018, 32'h01020304, 4'hC, 0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h26000014, 32'h0, 4'hF, TIMEOUT - 1, 1'b0, 32'hA5A50001);
    applyStimulus(1'b0, 32'h2600001C, 32'h0, 4'hF, TIMEOUT, 1'b0, 32'hA5A50002);
    dropCycTransfer(32'h26000020, 32'h11223344, 3);

    for (int n = 0; n < 40; n++) begin
      we     = 1'($urandom_range(0, 1));
      waits  = $urandom_range(0, TIMEOUT + 2);
      slverr = ($urandom_range(0, 5) == 0);
      applyStimulus(we, 32'h26000000 | ($urandom & 32'h00FF_FFFC), $urandom,
                    4'($urandom_range(0, 15)), waits, slverr, $urandom);
    end

    resetMidAccess();
    applyStimulus(1'b1, 32'h26000010, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h26000004, 32'h0, 4'hF, 2, 1'b0, 32'h12345678);

    repeat (3) @(negedge clk);
    checkOutput("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    checkOutput("apb_queue_drained", 32'(apb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
